// File: rtl/systolic_pkg.sv
// Shared types, default sizes and the saturating-add helper for the output-stationary systolic array.
// The helper is used only when SYSTOLIC_SAT_EN is defined.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int DEF_ROWS = 8;
    localparam int DEF_COLS = 8;
    localparam int DEF_DW   = 8;
    localparam int DEF_AW   = 32;
    localparam int DEF_KW   = 10;

    // Working width for the saturating add; accumulators must be narrower than this.
    localparam int SAT_W = 64;

    // Both operands arrive sign-extended to SAT_W, so the raw sum cannot overflow SAT_W.
    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] acc,
        input logic signed [SAT_W-1:0] prod,
        input int                      aw
    );
        logic signed [SAT_W-1:0] sum;
        logic signed [SAT_W-1:0] one;
        logic signed [SAT_W-1:0] max_v;
        logic signed [SAT_W-1:0] min_v;
        one   = SAT_W'(1);
        sum   = acc + prod;
        max_v = (one <<< (aw - 1)) - one;
        min_v = -(one <<< (aw - 1));
        if (sum > max_v) begin
            return max_v;
        end else if (sum < min_v) begin
            return min_v;
        end
        return sum;
    endfunction

endpackage

// File: rtl/systolic_pe_os.sv
// One output-stationary PE: forwards a east and b south through registers and accumulates a*b
// when both operands are valid. SYSTOLIC_SAT_EN selects a saturating accumulator.
module systolic_pe_os
    import systolic_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic [DW-1:0] a_in,
    input  logic          a_vin,
    input  logic [DW-1:0] b_in,
    input  logic          b_vin,
    output logic [DW-1:0] a_out,
    output logic          a_vout,
    output logic [DW-1:0] b_out,
    output logic          b_vout,
    output logic [AW-1:0] acc,
    output logic          sat
);

    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0]   prod_ext;
    logic signed [AW-1:0]   acc_q;
    logic signed [AW-1:0]   acc_next;
    logic                   clamp;
    logic                   sat_q;
    logic                   fire;

    assign prod     = $signed(a_in) * $signed(b_in);
    assign prod_ext = AW'(prod);
    assign fire     = a_vin && b_vin;

`ifdef SYSTOLIC_SAT_EN
    logic signed [SAT_W-1:0] wide_sum;
    logic signed [SAT_W-1:0] sat_sum;

    // A clamp is detected by the saturated result differing from the exact wide sum.
    assign wide_sum = SAT_W'(acc_q) + SAT_W'(prod_ext);
    assign sat_sum  = sat_add(SAT_W'(acc_q), SAT_W'(prod_ext), AW);
    assign acc_next = AW'(sat_sum);
    assign clamp    = (sat_sum != wide_sum);
`else
    assign acc_next = acc_q + prod_ext;
    assign clamp    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out  <= '0;
            a_vout <= 1'b0;
            b_out  <= '0;
            b_vout <= 1'b0;
            acc_q  <= '0;
            sat_q  <= 1'b0;
        end else begin
            a_out  <= a_in;
            a_vout <= a_vin;
            b_out  <= b_in;
            b_vout <= b_vin;
            if (clear) begin
                acc_q <= '0;
                sat_q <= 1'b0;
            end else if (fire) begin
                acc_q <= acc_next;
                sat_q <= sat_q | clamp;
            end
        end
    end

    assign acc = acc_q;
    assign sat = sat_q;

endmodule

// File: rtl/systolic_array_os.sv
// Output-stationary ROWS x COLS signed MAC array with internal skew and row-serial drain (ROWS >= 2).
// Define SYSTOLIC_SAT_EN for saturating accumulators and a live sat_flag.
module systolic_array_os
    import systolic_pkg::*;
#(
    parameter int ROWS = DEF_ROWS,
    parameter int COLS = DEF_COLS,
    parameter int DW   = DEF_DW,
    parameter int AW   = DEF_AW,
    parameter int KW   = DEF_KW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [KW-1:0]           k_len,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ROWS*DW-1:0]      a_in,
    input  logic [COLS*DW-1:0]      b_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [COLS*AW-1:0]      out_row,
    output logic [$clog2(ROWS)-1:0] out_idx,
    output logic                    busy,
    output logic                    done,
    output logic                    sat_flag
);

    localparam int IW         = $clog2(ROWS);
    localparam int FW         = $clog2(ROWS + COLS);
    localparam int FLUSH_LAST = ROWS + COLS - 2;

    state_t           state;
    state_t           state_next;
    logic [KW-1:0]    k_reg;
    logic [KW-1:0]    kcnt;
    logic [FW-1:0]    fcnt;
    logic             accept;
    logic             row_hs;
    logic             last_row;
    logic             clear_acc;

    logic [DW-1:0]    a_bus  [ROWS][COLS+1];
    logic [COLS:0]    a_vbus [ROWS];
    logic [DW-1:0]    b_bus  [ROWS+1][COLS];
    logic [ROWS:0]    b_vbus [COLS];
    logic [AW-1:0]    acc_arr [ROWS][COLS];
    logic [ROWS*COLS-1:0] sat_bits;

    assign in_ready  = (state == LOAD);
    assign out_valid = (state == DRAIN);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;
    assign row_hs    = out_valid && out_ready;
    assign last_row  = (out_idx == IW'(ROWS - 1));
    assign clear_acc = (state == IDLE) && start;
    assign sat_flag  = |sat_bits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (k_len == '0) ? DRAIN : LOAD;
                end
            end
            LOAD: begin
                if (accept && (kcnt == k_reg - KW'(1))) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (fcnt == FW'(FLUSH_LAST)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (row_hs && last_row) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // FLUSH covers the ROWS+COLS-1 cycles the last step needs to reach the far corner PE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_reg   <= '0;
            kcnt    <= '0;
            fcnt    <= '0;
            out_idx <= '0;
            done    <= 1'b0;
        end else begin
            done <= (state == DRAIN) && row_hs && last_row;
            case (state)
                IDLE: begin
                    if (start) begin
                        k_reg   <= k_len;
                        kcnt    <= '0;
                        out_idx <= '0;
                    end
                end
                LOAD: begin
                    if (accept) begin
                        kcnt <= kcnt + KW'(1);
                    end
                    fcnt <= '0;
                end
                FLUSH: begin
                    fcnt    <= fcnt + FW'(1);
                    out_idx <= '0;
                end
                DRAIN: begin
                    if (row_hs) begin
                        out_idx <= last_row ? '0 : out_idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Row i sees its operands i cycles late (depth i+1 including the capture stage).
    for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
        logic [DW-1:0] data [0:i];
        logic [i:0]    vld;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s <= i; s++) begin
                    data[s] <= '0;
                end
                vld <= '0;
            end else begin
                data[0] <= a_in[i*DW +: DW];
                vld[0]  <= accept;
                for (int s = 1; s <= i; s++) begin
                    data[s] <= data[s-1];
                    vld[s]  <= vld[s-1];
                end
            end
        end

        assign a_bus[i][0]  = data[i];
        assign a_vbus[i][0] = vld[i];
    end

    for (genvar j = 0; j < COLS; j++) begin : g_b_skew
        logic [DW-1:0] data [0:j];
        logic [j:0]    vld;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int s = 0; s <= j; s++) begin
                    data[s] <= '0;
                end
                vld <= '0;
            end else begin
                data[0] <= b_in[j*DW +: DW];
                vld[0]  <= accept;
                for (int s = 1; s <= j; s++) begin
                    data[s] <= data[s-1];
                    vld[s]  <= vld[s-1];
                end
            end
        end

        assign b_bus[0][j]  = data[j];
        assign b_vbus[j][0] = vld[j];
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            systolic_pe_os #(
                .DW(DW),
                .AW(AW)
            ) u_pe (
                .clk    (clk),
                .rst_n  (rst_n),
                .clear  (clear_acc),
                .a_in   (a_bus[i][j]),
                .a_vin  (a_vbus[i][j]),
                .b_in   (b_bus[i][j]),
                .b_vin  (b_vbus[j][i]),
                .a_out  (a_bus[i][j+1]),
                .a_vout (a_vbus[i][j+1]),
                .b_out  (b_bus[i+1][j]),
                .b_vout (b_vbus[j][i+1]),
                .acc    (acc_arr[i][j]),
                .sat    (sat_bits[i*COLS+j])
            );
        end
    end

    always_comb begin
        out_row = '0;
        for (int j = 0; j < COLS; j++) begin
            out_row[j*AW +: AW] = acc_arr[out_idx][j];
        end
    end

endmodule

// File: tb/tb_systolic_array_os.sv
// Directed self-checking bench for systolic_array_os: a 4x4 AW=32 instance plus a 4x4 AW=16
// instance for the overflow case; expectations follow SYSTOLIC_SAT_EN when it is defined.
module tb_systolic_array_os;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int DW   = 8;
    localparam int KW   = 10;
    localparam int AW   = 32;
    localparam int AW16 = 16;
    localparam int AWID = ROWS * DW;
    localparam int BWID = COLS * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n;
    logic                  start;
    logic                  start16;
    logic [KW-1:0]         k_len;
    logic                  in_valid;
    logic                  out_ready;
    logic [AWID-1:0]       a_in;
    logic [BWID-1:0]       b_in;

    logic                  in_ready32, out_valid32, busy32, done32, sat32;
    logic [COLS*AW-1:0]    out_row32;
    logic [1:0]            out_idx32;
    logic                  in_ready16, out_valid16, busy16, done16, sat16;
    logic [COLS*AW16-1:0]  out_row16;
    logic [1:0]            out_idx16;

    int errors = 0;
    int checks = 0;
    int mat_a [4][4];
    int mat_b [4][4];
    int exp_c [4][4];

    systolic_array_os #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW), .KW(KW)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready32), .a_in(a_in), .b_in(b_in),
        .out_valid(out_valid32), .out_ready(out_ready), .out_row(out_row32),
        .out_idx(out_idx32), .busy(busy32), .done(done32), .sat_flag(sat32)
    );

    systolic_array_os #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .AW(AW16), .KW(KW)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready16), .a_in(a_in), .b_in(b_in),
        .out_valid(out_valid16), .out_ready(out_ready), .out_row(out_row16),
        .out_idx(out_idx16), .busy(busy16), .done(done16), .sat_flag(sat16)
    );

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic int rowElem(input bit sel16, input int j);
        if (sel16) return int'($signed(out_row16[j*AW16 +: AW16]));
        return int'($signed(out_row32[j*AW +: AW]));
    endfunction

    function automatic int getIdx(input bit sel16);
        return sel16 ? int'(out_idx16) : int'(out_idx32);
    endfunction

    function automatic bit getValid(input bit sel16);
        return sel16 ? out_valid16 : out_valid32;
    endfunction

    function automatic bit getBusy(input bit sel16);
        return sel16 ? busy16 : busy32;
    endfunction

    function automatic bit getDone(input bit sel16);
        return sel16 ? done16 : done32;
    endfunction

    function automatic bit getReady(input bit sel16);
        return sel16 ? in_ready16 : in_ready32;
    endfunction

    task automatic checkOutput(input string tag, input longint observed, input longint expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives step s of the current matrices; bubbles carry random junk that must be ignored.
    task automatic applyStimulus(input int s, input bit valid);
        if (valid) begin
            for (int i = 0; i < ROWS; i++) a_in[i*DW +: DW] = DW'(mat_a[i][s]);
            for (int j = 0; j < COLS; j++) b_in[j*DW +: DW] = DW'(mat_b[s][j]);
        end else begin
            a_in = AWID'($urandom);
            b_in = BWID'($urandom);
        end
        in_valid = valid;
    endtask

    task automatic computeModel(input int k);
        for (int i = 0; i < ROWS; i++) begin
            for (int j = 0; j < COLS; j++) begin
                exp_c[i][j] = 0;
                for (int s = 0; s < k; s++) exp_c[i][j] += mat_a[i][s] * mat_b[s][j];
            end
        end
    endtask

    task automatic loadIdentityRamp();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                mat_a[i][j] = (i == j) ? 1 : 0;
                mat_b[i][j] = i * 4 + j;
            end
        end
    endtask

    task automatic fillAll(input int v);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                mat_a[i][j] = v;
                mat_b[i][j] = v;
            end
        end
    endtask

    task automatic checkRow(input string tag, input bit sel16, input int r);
        checkOutput($sformatf("%s_idx_r%0d", tag, r), getIdx(sel16), r);
        for (int j = 0; j < COLS; j++) begin
            checkOutput($sformatf("%s_c%0d%0d", tag, r, j), rowElem(sel16, j), exp_c[r][j]);
        end
    endtask

    task automatic runJob(input string tag, input int k, input bit gaps, input bit stall,
                          input bit sel16, input bit poke_start);
        int n;
        k_len = KW'(k);
        if (sel16) start16 = 1'b1; else start = 1'b1;
        tick();
        start   = 1'b0;
        start16 = 1'b0;
        checkOutput({tag, "_busy"}, getBusy(sel16), 1);
        for (int s = 0; s < k; s++) begin
            if (gaps) begin
                applyStimulus(s, 1'b0);
                tick();
            end
            applyStimulus(s, 1'b1);
            if (s == 0) checkOutput({tag, "_in_ready"}, getReady(sel16), 1);
            tick();
        end
        in_valid = 1'b0;
        n = 0;
        while (!getValid(sel16) && n < 40) begin
            tick();
            n++;
        end
        checkOutput({tag, "_flush_len"}, n, (k == 0) ? 0 : ROWS + COLS - 1);
        for (int r = 0; r < ROWS; r++) begin
            if (stall) begin
                out_ready = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    checkOutput({tag, "_stall_valid"}, getValid(sel16), 1);
                    checkRow({tag, "_stall"}, sel16, r);
                    tick();
                end
            end
            if (poke_start && r == 1) begin
                k_len = KW'(4);
                if (sel16) start16 = 1'b1; else start = 1'b1;
            end
            out_ready = 1'b1;
            checkOutput({tag, "_valid"}, getValid(sel16), 1);
            checkRow(tag, sel16, r);
            tick();
            start   = 1'b0;
            start16 = 1'b0;
            checkOutput($sformatf("%s_done_r%0d", tag, r), getDone(sel16), (r == ROWS - 1) ? 1 : 0);
        end
        out_ready = 1'b0;
        checkOutput({tag, "_idle"}, getBusy(sel16), 0);
        tick();
        checkOutput({tag, "_done_pulse"}, getDone(sel16), 0);
        checkOutput({tag, "_out_valid_end"}, getValid(sel16), 0);
    endtask

    task automatic checkCleared(input string tag);
        checkOutput({tag, "_busy"}, busy32, 0);
        checkOutput({tag, "_in_ready"}, in_ready32, 0);
        checkOutput({tag, "_out_valid"}, out_valid32, 0);
        checkOutput({tag, "_done"}, done32, 0);
        checkOutput({tag, "_sat"}, sat32, 0);
        checkOutput({tag, "_idx"}, out_idx32, 0);
        checkOutput({tag, "_row"}, out_row32, 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        start16   = 1'b0;
        k_len     = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = '0;
        b_in      = '0;
        tick();
        tick();
        checkCleared("reset");
        rst_n = 1'b1;
        tick();

        $display("[TB] test 1: identity x ramp");
        loadIdentityRamp();
        computeModel(4);
        runJob("t1", 4, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] test 2: all -128, K=3");
        fillAll(-128);
        computeModel(3);
        runJob("t2", 3, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t2_sat", sat32, 0);

        $display("[TB] test 3: bubbles and stalls");
        loadIdentityRamp();
        computeModel(4);
        runJob("t3", 4, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("[TB] test 4: k_len=0 with start during drain");
        computeModel(0);
        runJob("t4", 0, 1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] test 5: AW=16 overflow");
        fillAll(127);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
`ifdef SYSTOLIC_SAT_EN
                exp_c[i][j] = 32767;
`else
                exp_c[i][j] = -17149;
`endif
            end
        end
        runJob("t5", 3, 1'b0, 1'b0, 1'b1, 1'b0);
`ifdef SYSTOLIC_SAT_EN
        checkOutput("t5_sat", sat16, 1);
`else
        checkOutput("t5_sat", sat16, 0);
`endif
        computeModel(0);
        runJob("t5_clear", 0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("t5_sat_cleared", sat16, 0);

        $display("[TB] test 6: reset mid-LOAD");
        loadIdentityRamp();
        k_len = KW'(4);
        start = 1'b1;
        tick();
        start = 1'b0;
        applyStimulus(0, 1'b1);
        tick();
        applyStimulus(1, 1'b1);
        tick();
        applyStimulus(2, 1'b1);
        tick();
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkCleared("t6_async");
        tick();
        checkCleared("t6_held");
        rst_n = 1'b1;
        tick();
        checkOutput("t6_idle_after", busy32, 0);
        computeModel(4);
        runJob("t6_fresh", 4, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
